// File: rtl/subtractor_cla_pipe_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | subtractor_cla_pipe_if : operand/result valid-ready stream for the        |
// |                          pipelined subtractor.              Rev 1.0       |
// +---------------------------------------------------------------------------+
interface subtractor_cla_pipe_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bo;
  logic         ovf;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo, ovf
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo, ovf
  );
endinterface
`default_nettype wire

// File: rtl/subtractor_cla_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | subtractor_cla_pipe : N-bit a - b - bi, one K-bit lookahead slice per     |
// |                       pipeline stage, valid/ready stream.   Rev 1.0       |
// +---------------------------------------------------------------------------+
module subtractor_cla_pipe #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  subtractor_cla_pipe_if.slave bus
);
  localparam int S = N / K;

  if (K < 1 || K > N || (N % K) != 0) begin : g_param_check
    $error("subtractor_cla_pipe: K must divide N with 1 <= K <= N");
  end

  logic w_advance;

  for (genvar k = 0; k < S; k++) begin : g_stage
    // Each stage sees only the operand bits not yet consumed; its slice is the low K of them.
    localparam int RI = N - k * K;
    localparam int RO = RI - K;

    logic                 w_vin;
    logic                 w_cin;
    logic                 w_as;
    logic                 w_bs;
    logic [RI-1:0]        w_ain;
    logic [RI-1:0]        w_bin;
    logic [K:0]           w_sum;
    logic [(k+1)*K-1:0]   w_dnext;

    logic                 r_vld;
    logic                 r_cy;
    logic                 r_as;
    logic                 r_bs;
    logic [(k+1)*K-1:0]   r_d;

    if (k == 0) begin : g_head
      assign w_vin   = bus.in_valid;
      assign w_cin   = ~bus.bi;
      assign w_ain   = bus.a;
      assign w_bin   = bus.b;
      assign w_as    = bus.a[N-1];
      assign w_bs    = bus.b[N-1];
      assign w_dnext = w_sum[K-1:0];
    end else begin : g_body
      assign w_vin   = g_stage[k-1].r_vld;
      assign w_cin   = g_stage[k-1].r_cy;
      assign w_ain   = g_stage[k-1].g_keep.r_a;
      assign w_bin   = g_stage[k-1].g_keep.r_b;
      assign w_as    = g_stage[k-1].r_as;
      assign w_bs    = g_stage[k-1].r_bs;
      assign w_dnext = {w_sum[K-1:0], g_stage[k-1].r_d};
    end

    // Subtraction as a + ~b + carry, where carry is the inverted borrow.
    assign w_sum = {1'b0, w_ain[K-1:0]} + {1'b0, ~w_bin[K-1:0]} + {{K{1'b0}}, w_cin};

    if (RO > 0) begin : g_keep
      logic [RO-1:0] r_a;
      logic [RO-1:0] r_b;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_ain[RI-1:K];
          r_b <= w_bin[RI-1:K];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b1;
        r_as  <= 1'b0;
        r_bs  <= 1'b0;
        r_d   <= '0;
      end else if (w_advance) begin
        r_vld <= w_vin;
        r_cy  <= w_sum[K];
        r_as  <= w_as;
        r_bs  <= w_bs;
        r_d   <= w_dnext;
      end
    end
  end

  // Whole pipe moves in lockstep; a stalled head freezes every stage.
  assign w_advance     = !g_stage[S-1].r_vld || bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = g_stage[S-1].r_vld;
  assign bus.d         = g_stage[S-1].r_d;
  assign bus.bo        = ~g_stage[S-1].r_cy;
  assign bus.ovf       = (g_stage[S-1].r_as != g_stage[S-1].r_bs) &&
                         (g_stage[S-1].r_d[N-1] != g_stage[S-1].r_as);
endmodule
`default_nettype wire
